// File: rtl/corr_pkg.sv
// Shared definitions for the correlation peak path: default widths, peak
// result field layout and the peak detector FSM states.
package corr_pkg;

  localparam int unsigned CORR_W = 32;
  localparam int unsigned IDX_W  = 12;

  // Field offsets for the default widths
  localparam int unsigned MAG_LSB = 0;
  localparam int unsigned IDX_LSB = CORR_W;
  localparam int unsigned THR_BIT = CORR_W + IDX_W;
  localparam int unsigned OVF_BIT = CORR_W + IDX_W + 1;

  // Same layout for arbitrary widths
  function automatic int unsigned idx_lsb(input int unsigned cw);
    return cw;
  endfunction

  function automatic int unsigned thr_bit(input int unsigned cw, input int unsigned iw);
    return cw + iw;
  endfunction

  function automatic int unsigned ovf_bit(input int unsigned cw, input int unsigned iw);
    return cw + iw + 1;
  endfunction

  typedef enum logic {
    IDLE,
    ACCUM
  } corr_state_e;

endpackage

// File: rtl/corr_abs_sat.sv
// Combinational magnitude of a signed value; the most negative input
// saturates to the largest positive value so the result fits in W bits.
module corr_abs_sat #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_mag
);

  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};

  always_comb begin
    if (i_x == MinNeg) begin
      o_mag = MaxPos;
    end else if (i_x[W-1]) begin
      o_mag = (~i_x) + 1'b1;
    end else begin
      o_mag = i_x;
    end
  end

endmodule

// File: rtl/corr_peak_detect.sv
// Finds peak |correlation| and its lag in each AXIS frame and emits one
// result beat per frame {ovf, above_thr, idx, mag}.
module corr_peak_detect #(
  parameter int unsigned CORR_W = corr_pkg::CORR_W,
  parameter int unsigned IDX_W  = corr_pkg::IDX_W
) (
  input  logic                     sclk,
  input  logic                     reset,
  input  logic [CORR_W-1:0]        corr_axis_tdata,
  input  logic                     corr_axis_tvalid,
  input  logic                     corr_axis_tlast,
  output logic                     corr_axis_tready,
  input  logic [CORR_W-1:0]        threshold,
  output logic [CORR_W+IDX_W+1:0]  peak_axis_tdata,
  output logic                     peak_axis_tvalid,
  input  logic                     peak_axis_tready
);

  import corr_pkg::*;

  localparam int unsigned    OutW    = CORR_W + IDX_W + 2;
  localparam int unsigned    IdxLsb  = idx_lsb(CORR_W);
  localparam int unsigned    ThrBit  = thr_bit(CORR_W, IDX_W);
  localparam int unsigned    OvfBit  = ovf_bit(CORR_W, IDX_W);
  localparam logic [IDX_W-1:0] LagMax = '1;

  corr_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_lag, w_lag_nxt;
  logic                r_lag_sat, w_lag_sat_nxt;
  logic [CORR_W-1:0]   r_max, w_max_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic [OutW-1:0]     r_out_data;
  logic                r_out_valid;

  logic [CORR_W-1:0]   w_mag;
  logic                w_accept;
  logic                w_close;
  logic [OutW-1:0]     w_result;

  corr_abs_sat #(
    .W(CORR_W)
  ) u_abs (
    .i_x  (corr_axis_tdata),
    .o_mag(w_mag)
  );

  // Only a closing beat needs the output register free; other beats always flow.
  assign corr_axis_tready = !(r_out_valid & !peak_axis_tready & corr_axis_tlast);
  assign w_accept         = corr_axis_tvalid & corr_axis_tready;
  assign w_close          = w_accept & corr_axis_tlast;

  assign peak_axis_tdata  = r_out_data;
  assign peak_axis_tvalid = r_out_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_lag_nxt     = r_lag;
    w_lag_sat_nxt = r_lag_sat;
    w_max_nxt     = r_max;
    w_idx_nxt     = r_idx;
    w_ovf_nxt     = r_ovf;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          w_max_nxt     = w_mag;
          w_idx_nxt     = '0;
          w_ovf_nxt     = 1'b0;
          w_lag_nxt     = IDX_W'(1);
          w_lag_sat_nxt = 1'b0;
          w_state_nxt   = ACCUM;
        end
        ACCUM: begin
          if (w_mag > r_max) begin
            w_max_nxt = w_mag;
            if (!r_lag_sat) w_idx_nxt = r_lag;
          end
          if (r_lag_sat) w_ovf_nxt = 1'b1;
          // Beat at lag LagMax is still indexable; only later beats overflow.
          if (r_lag == LagMax) begin
            w_lag_sat_nxt = 1'b1;
          end else begin
            w_lag_nxt = r_lag + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (corr_axis_tlast) w_state_nxt = IDLE;
    end
  end

  always_comb begin
    w_result                   = '0;
    w_result[CORR_W-1:0]       = w_max_nxt;
    w_result[IdxLsb +: IDX_W]  = w_idx_nxt;
    w_result[ThrBit]           = (w_max_nxt >= threshold);
    w_result[OvfBit]           = w_ovf_nxt;
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lag       <= '0;
      r_lag_sat   <= 1'b0;
      r_max       <= '0;
      r_idx       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_out_valid && peak_axis_tready) r_out_valid <= 1'b0;
      if (w_close) begin
        r_lag       <= '0;
        r_lag_sat   <= 1'b0;
        r_max       <= '0;
        r_idx       <= '0;
        r_ovf       <= 1'b0;
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end else begin
        r_lag     <= w_lag_nxt;
        r_lag_sat <= w_lag_sat_nxt;
        r_max     <= w_max_nxt;
        r_idx     <= w_idx_nxt;
        r_ovf     <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_corr_peak_detect.sv
// Scoreboard bench for corr_peak_detect: frames are driven, expected results
// queued from a reference model, and a monitor pops on each output handshake.
module tb_corr_peak_detect;

  localparam int unsigned CW     = 32;
  localparam int unsigned IW     = 4;
  localparam int unsigned OW     = CW + IW + 2;
  localparam int          MAXLAG = 1 << IW;

  typedef logic [OW-1:0] res_t;

  logic          sclk;
  logic          reset;
  logic [CW-1:0] corr_tdata;
  logic          corr_tvalid;
  logic          corr_tlast;
  logic          corr_tready;
  logic [CW-1:0] threshold;
  res_t          peak_tdata;
  logic          peak_tvalid;
  logic          peak_tready;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  res_t exp_q[$];

  corr_peak_detect #(
    .CORR_W(CW),
    .IDX_W (IW)
  ) dut (
    .sclk            (sclk),
    .reset           (reset),
    .corr_axis_tdata (corr_tdata),
    .corr_axis_tvalid(corr_tvalid),
    .corr_axis_tlast (corr_tlast),
    .corr_axis_tready(corr_tready),
    .threshold       (threshold),
    .peak_axis_tdata (peak_tdata),
    .peak_axis_tvalid(peak_tvalid),
    .peak_axis_tready(peak_tready)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    peak_tready = 1'b1;
    forever begin
      @(posedge sclk);
      #1;
      if (rdy_mode == 2) peak_tready = ($urandom_range(0, 99) < 70);
      else               peak_tready = (rdy_mode == 1);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [CW-1:0] s[$], input logic [CW-1:0] thr);
    logic [CW-1:0] m;
    logic [CW-1:0] mx;
    logic [IW-1:0] ix;
    mx = '0;
    ix = '0;
    foreach (s[i]) begin
      if (s[i] == 32'h8000_0000) m = 32'h7fff_ffff;
      else if (s[i][CW-1])       m = -s[i];
      else                       m = s[i];
      if (i == 0 || m > mx) begin
        mx = m;
        if (i < MAXLAG) ix = i[IW-1:0];
      end
    end
    return {(s.size() > MAXLAG), (mx >= thr), ix, mx};
  endfunction

  // Monitor: compare on every output handshake, and require stable data while stalled.
  initial begin
    logic hold;
    res_t held;
    res_t e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge sclk);
      if (reset) begin
        hold = 1'b0;
      end else if (peak_tvalid) begin
        if (hold) check("hold_stable", 64'(peak_tdata), 64'(held));
        if (peak_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(peak_tdata), 64'hdead);
          end else begin
            e = exp_q.pop_front();
            check("result", 64'(peak_tdata), 64'(e));
          end
        end
        hold = !peak_tready;
        held = peak_tdata;
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Drives one frame; no_last leaves the frame open (for reset tests).
  task automatic send_frame(input logic [CW-1:0] s[$], input logic [CW-1:0] thr,
                            input int gap_pct, input bit no_last, output int tl_stall);
    int cyc;
    bit last;
    tl_stall = 0;
    for (int i = 0; i < s.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        corr_tvalid = 1'b0;
        @(posedge sclk);
        #1;
      end
      last        = (i == s.size() - 1) && !no_last;
      corr_tvalid = 1'b1;
      corr_tdata  = s[i];
      corr_tlast  = last;
      threshold   = last ? thr : $urandom();
      cyc = 0;
      forever begin
        @(negedge sclk);
        if (corr_tready) break;
        if (!last) check("nonfinal_stall", 64'(i), 64'hffff);
        tl_stall++;
        cyc++;
        if (cyc > 400) break;
      end
      if (cyc > 400) begin
        check("tready_timeout", 64'(cyc), 64'd0);
        corr_tvalid = 1'b0;
        corr_tlast  = 1'b0;
        return;
      end
      if (last) exp_q.push_back(model(s, thr));
      @(posedge sclk);
      #1;
    end
    corr_tvalid = 1'b0;
    corr_tlast  = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    rdy_mode = 1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge sclk);
      cyc++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge sclk);
    #1;
  endtask

  initial begin
    logic [CW-1:0] fr[$];
    logic [CW-1:0] thr;
    int st, st2;
    int len;

    reset = 1'b1;
    corr_tvalid = 1'b0;
    corr_tlast  = 1'b0;
    corr_tdata  = '0;
    threshold   = '0;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_tvalid", 64'(peak_tvalid), 64'd0);
    check("rst_tdata", 64'(peak_tdata), 64'd0);
    check("rst_tready", 64'(corr_tready), 64'd1);
    reset = 1'b0;
    @(posedge sclk);
    #1;

    // Basic frame, one-cycle latency
    fr = '{32'd3, -32'sd9, 32'd4, 32'd9, -32'sd2, 32'd0, 32'd1, 32'd5};
    check("pre_tvalid", 64'(peak_tvalid), 64'd0);
    send_frame(fr, 32'd8, 0, 1'b0, st);
    check("lat1_tvalid", 64'(peak_tvalid), 64'd1);
    check("basic_data", 64'(peak_tdata), 64'({1'b0, 1'b1, 4'd1, 32'd9}));
    drain();

    // Single-sample most negative value
    fr = '{32'h8000_0000};
    send_frame(fr, 32'd0, 0, 1'b0, st);
    check("single_data", 64'(peak_tdata), 64'({1'b0, 1'b1, 4'd0, 32'h7fff_ffff}));
    fr = '{32'd7, -32'sd12, 32'd2};
    send_frame(fr, 32'd12, 0, 1'b0, st);
    check("after_single", 64'(peak_tdata), 64'({1'b0, 1'b1, 4'd1, 32'd12}));
    drain();

    // All zeros, length 16 (largest frame without overflow)
    fr = {};
    for (int i = 0; i < 16; i++) fr.push_back(32'd0);
    send_frame(fr, 32'd1, 0, 1'b0, st);
    check("zeros_data", 64'(peak_tdata), 64'd0);
    drain();

    // Back-to-back frames while output is blocked for 20 cycles
    rdy_mode = 0;
    @(posedge sclk);
    #1;
    fork
      begin
        fr = '{32'd1, 32'd50, -32'sd3, 32'd4, 32'd2};
        send_frame(fr, 32'd10, 0, 1'b0, st);
        fr = '{-32'sd70, 32'd6, 32'd70, 32'd1, 32'd0, 32'd3};
        send_frame(fr, 32'd100, 0, 1'b0, st2);
      end
      begin
        repeat (20) @(posedge sclk);
        rdy_mode = 1;
      end
    join
    check("b2b_tlast_held", 64'(st2 > 0), 64'd1);
    drain();

    // Overflow: 20 samples, peak at lag 18
    fr = {};
    for (int i = 0; i < 20; i++) fr.push_back(32'($urandom_range(0, 100)));
    fr[18] = -32'sd5000;
    send_frame(fr, 32'd4000, 0, 1'b0, st);
    check("ovf_flag", 64'(peak_tdata[OW-1]), 64'd1);
    check("ovf_mag", 64'(peak_tdata[CW-1:0]), 64'd5000);
    fr = {};
    for (int i = 0; i < 17; i++) fr.push_back(32'(i));
    send_frame(fr, 32'd0, 0, 1'b0, st);
    check("len17_data", 64'(peak_tdata), 64'({1'b1, 1'b1, 4'd15, 32'd16}));
    drain();

    // Reset mid-frame discards the partial frame
    fr = {};
    for (int i = 0; i < 5; i++) fr.push_back(32'd900 + 32'(i));
    send_frame(fr, 32'd0, 0, 1'b1, st);
    reset = 1'b1;
    @(posedge sclk);
    #1;
    reset = 1'b0;
    check("midrst_tvalid", 64'(peak_tvalid), 64'd0);
    fr = '{32'd2, 32'd8, -32'sd8, 32'd1};
    send_frame(fr, 32'd9, 0, 1'b0, st);
    check("post_rst_data", 64'(peak_tdata), 64'({1'b0, 1'b0, 4'd1, 32'd8}));
    drain();

    // Reset drops a pending result
    rdy_mode = 0;
    @(posedge sclk);
    #1;
    fr = '{32'd44, 32'd3};
    send_frame(fr, 32'd0, 0, 1'b0, st);
    reset = 1'b1;
    @(posedge sclk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("pend_rst_tvalid", 64'(peak_tvalid), 64'd0);
    check("pend_rst_tdata", 64'(peak_tdata), 64'd0);
    drain();

    // Randomized frames with random gaps and random downstream ready
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      fr = {};
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 9))
          0:       fr.push_back(32'h8000_0000);
          1:       fr.push_back(32'h7fff_ffff);
          2:       fr.push_back(32'h8000_0001);
          3:       fr.push_back(32'd0);
          default: fr.push_back(32'($urandom_range(0, 200)) - 32'd100);
        endcase
      end
      thr = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 120));
      send_frame(fr, thr, 30, 1'b0, st);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
